// File: rtl/if_fetch_ctrl_if.sv
// Instruction memory read bus between the fetch controller and imem.
// The request is held with a stable address until ack; ack may land in the request cycle.
interface if_fetch_ctrl_if;
    logic        req;
    logic [15:0] addr;
    logic        ack;
    logic [15:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/if_fetch_ctrl.sv
// Fetch controller: gates the PC, issues imem reads and loads the IF/ID register.
// A one-entry hold buffer absorbs decode stalls; DRAIN retires a fetch orphaned by a flush.
module if_fetch_ctrl #(
    parameter logic [3:0]  HLT_OPCODE = 4'hF,
    parameter logic [15:0] NOP_INSTR  = 16'h0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [15:0]            pc_in,
    output logic                   pc_stall,
    output logic                   hlt_out,
    if_fetch_ctrl_if.master        mem,
    input  logic                   id_stall,
    input  logic                   flush,
    output logic [15:0]            instr_out,
    output logic [15:0]            instr_pc,
    output logic                   instr_valid
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        HOLD,
        DRAIN,
        HALTED
    } state_t;

    state_t      state;
    logic [15:0] hold_data;
    logic [15:0] hold_pc;
    logic [15:0] drain_addr;

    logic        fetch_done;
    logic        hold_rel;
    logic        load;
    logic [15:0] ld_data;
    logic [15:0] ld_pc;
    logic        ld_halt;

    assign fetch_done = (state == REQ) && mem.ack && !id_stall && !flush;
    assign hold_rel   = (state == HOLD) && !id_stall && !flush;
    assign load       = fetch_done || hold_rel;

    assign ld_data = (state == HOLD) ? hold_data : mem.rdata;
    assign ld_pc   = (state == HOLD) ? hold_pc : pc_in;
    assign ld_halt = (ld_data[15:12] == HLT_OPCODE);

    // The PC may advance only when an instruction is consumed or redirected.
    assign pc_stall = !(fetch_done || hold_rel || flush);

    assign mem.req  = (state == REQ) || (state == DRAIN);
    assign mem.addr = (state == DRAIN) ? drain_addr : pc_in;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            instr_out   <= NOP_INSTR;
            instr_pc    <= 16'h0000;
            instr_valid <= 1'b0;
            hlt_out     <= 1'b0;
            hold_data   <= 16'h0000;
            hold_pc     <= 16'h0000;
            drain_addr  <= 16'h0000;
        end else begin
            // Bubble unless a load below overrides; a stalled decode keeps its word.
            if (flush || !id_stall) begin
                instr_valid <= 1'b0;
            end
            if (load) begin
                instr_out   <= ld_data;
                instr_pc    <= ld_pc;
                instr_valid <= 1'b1;
            end

            unique case (state)
                IDLE: begin
                    state <= REQ;
                end
                REQ: begin
                    if (flush) begin
                        if (!mem.ack) begin
                            drain_addr <= pc_in;
                            state      <= DRAIN;
                        end
                    end else if (mem.ack) begin
                        if (!id_stall) begin
                            if (ld_halt) begin
                                state   <= HALTED;
                                hlt_out <= 1'b1;
                            end
                        end else begin
                            hold_data <= mem.rdata;
                            hold_pc   <= pc_in;
                            state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (flush) begin
                        state <= REQ;
                    end else if (!id_stall) begin
                        if (ld_halt) begin
                            state   <= HALTED;
                            hlt_out <= 1'b1;
                        end else begin
                            state <= REQ;
                        end
                    end
                end
                DRAIN: begin
                    if (!flush && mem.ack) begin
                        state <= REQ;
                    end
                end
                HALTED: begin
                    if (flush) begin
                        hlt_out <= 1'b0;
                        state   <= REQ;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed scenarios then random traffic,
// checked every cycle against a transaction-level model of the fetch unit.
module tb_if_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] pc_in;
    logic        pc_stall;
    logic        hlt_out;
    logic        id_stall;
    logic        flush;
    logic [15:0] instr_out;
    logic [15:0] instr_pc;
    logic        instr_valid;

    if_fetch_ctrl_if mem ();

    if_fetch_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_in       (pc_in),
        .pc_stall    (pc_stall),
        .hlt_out     (hlt_out),
        .mem         (mem),
        .id_stall    (id_stall),
        .flush       (flush),
        .instr_out   (instr_out),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Model: boot bubble, halted, draining, and a queue for the held word.
    bit          m_known;
    bit          m_boot;
    bit          m_halted;
    bit          m_drain;
    logic [15:0] m_daddr;
    logic [15:0] m_pc;
    logic [15:0] m_iout;
    logic [15:0] m_ipc;
    bit          m_ivalid;
    bit          m_hlt;
    logic [15:0] q_data[$];
    logic [15:0] q_pc[$];

    task automatic m_load(input logic [15:0] d, input logic [15:0] p);
        m_iout   = d;
        m_ipc    = p;
        m_ivalid = 1'b1;
        if (d[15:12] == 4'hF) begin
            m_halted = 1'b1;
            m_hlt    = 1'b1;
        end
    endtask

    task automatic cyc(input bit r, input bit a, input bit s, input bit f,
                       input bit h, input logic [15:0] tgt);
        bit          req;
        bit          fetch;
        bit          ack;
        bit          done;
        bit          rel;
        bit          xstall;
        logic [15:0] addr;
        logic [15:0] rd;
        @(negedge clk);
        req   = m_known && !m_boot && !m_halted && (q_data.size() == 0);
        fetch = req && !m_drain;
        addr  = m_drain ? m_daddr : m_pc;
        ack   = a && req;
        rd    = h ? {4'hF, addr[11:0]} : (addr ^ 16'hA5A5);
        rst_n     = r;
        id_stall  = s;
        flush     = f;
        pc_in     = m_pc;
        mem.ack   = ack;
        mem.rdata = rd;
        done   = fetch && ack && !s && !f;
        rel    = (q_data.size() != 0) && !s;
        xstall = !(done || rel || f);
        #1;
        if (m_known) begin
            chk("instr_valid", 16'(instr_valid), 16'(m_ivalid));
            chk("instr_out", instr_out, m_iout);
            chk("instr_pc", instr_pc, m_ipc);
            chk("hlt_out", 16'(hlt_out), 16'(m_hlt));
            chk("mem_req", 16'(mem.req), 16'(req));
            chk("pc_stall", 16'(pc_stall), 16'(xstall));
            if (req) chk("mem_addr", mem.addr, addr);
        end
        @(posedge clk);
        if (!r) begin
            m_known  = 1'b1;
            m_boot   = 1'b1;
            m_halted = 1'b0;
            m_drain  = 1'b0;
            m_iout   = 16'h0000;
            m_ipc    = 16'h0000;
            m_ivalid = 1'b0;
            m_hlt    = 1'b0;
            q_data.delete();
            q_pc.delete();
        end else if (m_known) begin
            if (f || !s) m_ivalid = 1'b0;
            if (f) begin
                if (m_boot) m_boot = 1'b0;
                else if (m_halted) begin
                    m_halted = 1'b0;
                    m_hlt    = 1'b0;
                end else if (q_data.size() != 0) begin
                    q_data.delete();
                    q_pc.delete();
                end else if (!m_drain && !ack) begin
                    m_drain = 1'b1;
                    m_daddr = addr;
                end
            end else if (m_boot) begin
                m_boot = 1'b0;
            end else if (m_halted) begin
                m_halted = 1'b1;
            end else if (q_data.size() != 0) begin
                if (!s) m_load(q_data.pop_front(), q_pc.pop_front());
            end else if (m_drain) begin
                if (ack) m_drain = 1'b0;
            end else if (ack) begin
                if (!s) m_load(rd, addr);
                else begin
                    q_data.push_back(rd);
                    q_pc.push_back(addr);
                end
            end
            if (!xstall) m_pc = f ? tgt : m_pc + 16'd1;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        id_stall  = 1'b0;
        flush     = 1'b0;
        pc_in     = 16'h0000;
        mem.ack   = 1'b0;
        mem.rdata = 16'h0000;
        m_known   = 1'b0;
        m_boot    = 1'b0;
        m_halted  = 1'b0;
        m_drain   = 1'b0;
        m_daddr   = 16'h0000;
        m_pc      = 16'h0000;
        m_iout    = 16'h0000;
        m_ipc     = 16'h0000;
        m_ivalid  = 1'b0;
        m_hlt     = 1'b0;

        cyc(0, 0, 0, 0, 0, 16'h0);
        cyc(0, 0, 0, 0, 0, 16'h0);
        repeat (4) cyc(1, 1, 0, 0, 0, 16'h0);
        cyc(1, 0, 0, 1, 0, 16'h0010);
        cyc(1, 1, 0, 0, 0, 16'h0);
        repeat (3) cyc(1, 0, 0, 0, 0, 16'h0);
        cyc(1, 1, 0, 0, 0, 16'h0);
        cyc(1, 1, 1, 0, 0, 16'h0);
        cyc(1, 0, 1, 0, 0, 16'h0);
        cyc(1, 0, 1, 0, 0, 16'h0);
        cyc(1, 0, 0, 0, 0, 16'h0);
        cyc(1, 1, 0, 0, 0, 16'h0);
        cyc(1, 1, 0, 1, 0, 16'h0020);
        cyc(1, 0, 0, 1, 0, 16'h0080);
        cyc(1, 0, 0, 0, 0, 16'h0);
        cyc(1, 1, 0, 0, 0, 16'h0);
        cyc(1, 1, 0, 0, 0, 16'h0);
        cyc(1, 1, 0, 0, 1, 16'h0);
        repeat (4) cyc(1, 1, 0, 0, 0, 16'h0);
        cyc(1, 1, 0, 1, 0, 16'h0300);
        repeat (2) cyc(1, 1, 0, 0, 0, 16'h0);
        cyc(1, 0, 0, 1, 0, 16'h0400);
        cyc(1, 0, 0, 0, 0, 16'h0);
        cyc(0, 1, 0, 0, 0, 16'h0);
        repeat (3) cyc(1, 1, 0, 0, 0, 16'h0);

        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 200) != 0, ($urandom % 3) != 0,
                ($urandom % 4) == 0, ($urandom % 10) == 0,
                ($urandom % 25) == 0, 16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
